// File: rtl/sync_mem_responder.sv
// sync_mem_responder
// Memory-side target for the sel/wen/ren/ack bus. It accepts one level-held
// read or write request, services it from an internal word array after
// LATENCY cycles, and returns read data, an error flag and a one-cycle ack.
//
// Ports
//   clk_i    : memory-domain clock, rising edge
//   rst_i    : asynchronous active-high reset
//   addr_i   : byte address of the request
//   wdata_i  : write data
//   sel_i    : chip select, qualifies wen_i/ren_i
//   wen_i    : write request level (wins over ren_i)
//   ren_i    : read request level
//   rdata_o  : read data, valid while ack_o is high, held until next response
//   err_o    : error status of the last response, held until next response
//   ack_o    : one-cycle response strobe

`timescale 1ns/1ps

module sync_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  sel_i,
    input  logic                  wen_i,
    input  logic                  ren_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  ack_o
);

    localparam int unsigned LSB   = $clog2(DATA_WIDTH / 8);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [CNT_W-1:0]      LAT_LOAD   = CNT_W'(LATENCY - 1);
    // Byte-offset bits below the word index; zero-width offset gives a zero mask.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = (ADDR_WIDTH'(1) << LSB) - ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACK   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Sequential state
    state_t                 state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [IDX_W-1:0]       req_idx_q,   req_idx_d;
    logic [DATA_WIDTH-1:0]  req_wdata_q, req_wdata_d;
    logic                   req_we_q,    req_we_d;
    logic                   req_err_q,   req_err_d;
    logic                   ack_q,       ack_d;
    logic                   err_q,       err_d;
    logic [DATA_WIDTH-1:0]  rdata_q,     rdata_d;

    // Word array, deliberately without reset
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    // Request decode
    logic                   req_c;
    logic [ADDR_WIDTH-1:0]  word_full_c;
    logic                   addr_err_c;
    logic                   mem_we_c;

    assign req_c       = sel_i & (wen_i | ren_i);
    assign word_full_c = addr_i >> LSB;
    assign addr_err_c  = (|(addr_i & ALIGN_MASK)) | (word_full_c >= DEPTH_A);

    // Array write happens on the same edge that raises ack.
    assign mem_we_c = (state_q == ST_WAIT) && (cnt_q == '0) && req_we_q && !req_err_q;

    // Next-state and response logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_idx_d   = req_idx_q;
        req_wdata_d = req_wdata_q;
        req_we_d    = req_we_q;
        req_err_d   = req_err_q;
        ack_d       = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    req_idx_d   = IDX_W'(word_full_c);
                    req_wdata_d = wdata_i;
                    req_we_d    = wen_i;
                    req_err_d   = addr_err_c;
                    // LATENCY==1 loads 0 so the very next edge is the ack edge.
                    cnt_d       = LAT_LOAD;
                    state_d     = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // Bus inputs are ignored here; only captured values are used.
                if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    ack_d   = 1'b1;
                    err_d   = req_err_q;
                    if (req_err_q) begin
                        rdata_d = '0;
                    end else if (!req_we_q) begin
                        rdata_d = mem_q[req_idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_ACK: begin
                // A still-held request must be released before re-acceptance.
                state_d = req_c ? ST_DRAIN : ST_IDLE;
            end

            ST_DRAIN: begin
                if (!req_c) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            req_idx_q   <= '0;
            req_wdata_q <= '0;
            req_we_q    <= 1'b0;
            req_err_q   <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_idx_q   <= req_idx_d;
            req_wdata_q <= req_wdata_d;
            req_we_q    <= req_we_d;
            req_err_q   <= req_err_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Array write port; reset only blocks it through state_q
    always_ff @(posedge clk_i) begin
        if (mem_we_c) begin
            mem_q[req_idx_q] <= req_wdata_q;
        end
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign ack_o   = ack_q;

endmodule

// File: tb/tb_sync_mem_responder.sv
// tb_sync_mem_responder
// Directed bench for sync_mem_responder: one instance at LATENCY=2 and one at
// LATENCY=1. Expected responses come from a small word-array model and are
// queued when a request is driven, then popped and checked on ack.

`timescale 1ns/1ps

module tb_sync_mem_responder;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          sel0, wen0, ren0, sel1, wen1, ren1;
    logic [DW-1:0] rdata0, rdata1;
    logic          err0, err1, ack0, ack1;

    sync_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(2)) dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr0), .wdata_i(wdata0),
        .sel_i(sel0), .wen_i(wen0), .ren_i(ren0),
        .rdata_o(rdata0), .err_o(err0), .ack_o(ack0)
    );

    sync_mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .addr_i(addr1), .wdata_i(wdata1),
        .sel_i(sel1), .wen_i(wen1), .ren_i(ren1),
        .rdata_o(rdata1), .err_o(err1), .ack_o(ack1)
    );

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] mm [longint];
    logic [DW-1:0] last_rd [2];
    int            n_total = 0;
    int            n_pass  = 0;
    int            n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic s, input logic w, input logic r,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (u == 0) begin
            sel0 = s; wen0 = w; ren0 = r; addr0 = a; wdata0 = d;
        end else begin
            sel1 = s; wen1 = w; ren1 = r; addr1 = a; wdata1 = d;
        end
    endtask

    function automatic logic ack_of(input int u);
        return (u == 0) ? ack0 : ack1;
    endfunction

    function automatic logic err_of(input int u);
        return (u == 0) ? err0 : err1;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int u);
        return (u == 0) ? rdata0 : rdata1;
    endfunction

    // Reference behaviour of one accepted request; updates the array model.
    function automatic exp_t model_req(input int u, input logic [AW-1:0] a,
                                       input logic [DW-1:0] d, input logic w);
        exp_t          e;
        logic [AW-1:0] idx;
        longint        key;
        idx = a >> 2;
        key = longint'(u) * 64'h1_0000_0000 + longint'(idx);
        e.err = (a[1:0] != 2'b00) || (idx >= AW'(DEPTH));
        if (e.err) begin
            e.rdata = '0;
        end else if (w) begin
            mm[key] = d;
            e.rdata = last_rd[u];
        end else begin
            e.rdata = mm[key];
        end
        last_rd[u] = e.rdata;
        return e;
    endfunction

    // One request held until ack, then released; checks latency, response and ack width.
    task automatic xact(input int u, input string tag, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic w, input logic r, input int lat);
        exp_t e;
        int   cyc;
        logic got;
        sb_q.push_back(model_req(u, a, d, w));
        drive(u, 1'b1, w, r, a, d);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            tick();
            cyc++;
            if (ack_of(u)) got = 1'b1;
        end
        drive(u, 1'b0, 1'b0, 1'b0, a, d);
        // First tick is the acceptance edge.
        chk({tag, "_latency"}, 64'(cyc - 1), 64'(lat));
        e = sb_q.pop_front();
        if (got) begin
            chk({tag, "_err"}, 64'(err_of(u)), 64'(e.err));
            chk({tag, "_rdata"}, 64'(rdata_of(u)), 64'(e.rdata));
        end
        tick();
        chk({tag, "_ack_fall"}, 64'(ack_of(u)), 64'(0));
    endtask

    // Asynchronous reset between edges, then 5 quiet cycles after release.
    task automatic async_reset_check(input string tag);
        #3;
        rst = 1'b1;
        #1;
        chk({tag, "_ack_imm"}, 64'(ack0), 64'(0));
        chk({tag, "_err_imm"}, 64'(err0), 64'(0));
        chk({tag, "_rdata_imm"}, 64'(rdata0), 64'(0));
        last_rd[0] = '0;
        last_rd[1] = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk({tag, "_quiet"}, {31'(0), ack0, err0, rdata0}, 64'(0));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
        int   n_ack;

        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, 1'b0, '0, '0);
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post_reset", {31'(0), ack0, err0, rdata0}, 64'(0));

        // Basic write then read at LATENCY=2
        xact(0, "wr10", 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0, 2);
        xact(0, "rd10", 32'h10, 32'h0, 1'b0, 1'b1, 2);
        async_reset_check("rst_after_read");

        // Error responses
        xact(0, "rd13_misaligned", 32'h13, 32'h0, 1'b0, 1'b1, 2);
        async_reset_check("rst_after_err");
        xact(0, "wr0", 32'h0, 32'h1111_1111, 1'b1, 1'b0, 2);
        xact(0, "wr_oob", 32'(DEPTH * 4), 32'hFFFF_FFFF, 1'b1, 1'b0, 2);
        xact(0, "rd0_after_oob", 32'h0, 32'h0, 1'b0, 1'b1, 2);

        // Level-held read: exactly one ack, then one-cycle release and re-request
        sb_q.push_back(model_req(0, 32'h10, 32'h0, 1'b0));
        drive(0, 1'b1, 1'b0, 1'b1, 32'h10, 32'h0);
        n_ack = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ack0) begin
                n_ack++;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("hold_rdata", 64'(rdata0), 64'(e.rdata));
                    chk("hold_err", 64'(err0), 64'(e.err));
                end
            end
        end
        chk("hold_ack_count", 64'(n_ack), 64'(1));
        drive(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
        tick();
        xact(0, "rd10_rerequest", 32'h10, 32'h0, 1'b0, 1'b1, 2);

        // Write wins over read; select gates requests
        xact(0, "wr20_both", 32'h20, 32'h0000_1234, 1'b1, 1'b1, 2);
        xact(0, "rd20", 32'h20, 32'h0, 1'b0, 1'b1, 2);
        drive(0, 1'b0, 1'b1, 1'b0, 32'h20, 32'hFFFF_FFFF);
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack0) n_ack++;
        end
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("nosel_ack_count", 64'(n_ack), 64'(0));
        xact(0, "rd20_after_nosel", 32'h20, 32'h0, 1'b0, 1'b1, 2);

        // Reset one cycle after accepting a write discards it
        xact(0, "wr40", 32'h40, 32'hA5A5_A5A5, 1'b1, 1'b0, 2);
        drive(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h5A5A_5A5A);
        tick();
        drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midwait_rst_ack", 64'(ack0), 64'(0));
        last_rd[0] = '0;
        last_rd[1] = '0;
        tick();
        tick();
        rst = 1'b0;
        n_ack = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack0) n_ack++;
        end
        chk("midwait_no_ack", 64'(n_ack), 64'(0));
        xact(0, "rd40_after_rst", 32'h40, 32'h0, 1'b0, 1'b1, 2);

        // LATENCY=1 instance
        xact(1, "l1_wr8", 32'h8, 32'hCAFE_F00D, 1'b1, 1'b0, 1);
        xact(1, "l1_rd8", 32'h8, 32'h0, 1'b0, 1'b1, 1);
        xact(1, "l1_rd_oob", 32'(DEPTH * 4 + 4), 32'h0, 1'b0, 1'b1, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sync_mem_responder.md
# sync_mem_responder

Single-clock memory-side responder for the simple sel/wen/ren/ack bus driven by the AXI-to-memory clock-domain bridge. It accepts a level-held read or write request, services it from an internal word array after a fixed, programmable latency, and returns read data, an error flag and a one-cycle acknowledge. It sits in the memory clock domain of the testbench subsystem, as the target end of the bridge's `mem_*` outputs.

## Interface
- `ADDR_WIDTH`, 32, byte-address width.
- `DATA_WIDTH`, 32, word width; a power of two and at least 8.
- `DEPTH`, 1024, number of words in the array.
- `LATENCY`, 2, cycles from request acceptance to ack; must be at least 1.
- `clk_i`  input  1  memory-domain clock, rising edge.
- `rst_i`  input  1  reset, asynchronous and active-high.
- `addr_i`  input  ADDR_WIDTH  byte address of the request.
- `wdata_i`  input  DATA_WIDTH  write data.
- `sel_i`  input  1  chip select; a request is valid only while this is high.
- `wen_i`  input  1  write request level.
- `ren_i`  input  1  read request level.
- `rdata_o`  output  DATA_WIDTH  read data; valid while `ack_o` is high.
- `err_o`  output  1  error status of the response.
- `ack_o`  output  1  one-cycle response strobe.

## Operation
- Request: `req = sel_i & (wen_i | ren_i)`. If `wen_i` and `ren_i` are both high, the request is a write.
- Let `LSB = log2(DATA_WIDTH/8)` and word index `idx = addr_i >> LSB`.
- A request is erroneous when `addr_i[LSB-1:0] != 0` or `idx >= DEPTH`.
- State machine states are IDLE, WAIT, ACK and DRAIN.
- **IDLE**
  - On `req`, capture `addr_i`, `wdata_i`, the write flag and the error flag.
  - Load the counter with `LATENCY-1` and go to WAIT.
  - If `LATENCY == 1`, go directly to the ack edge; WAIT lasts 0 cycles.
  - With no `req`, stay in IDLE.
- **WAIT**
  - Decrement the counter.
  - When the counter is 0, go to ACK on the next edge.
  - Request inputs are ignored during WAIT; the captured values are used.
- **Entering ACK** (a single edge)
  - Set `ack_o = 1` and `err_o` = the captured error flag.
  - For a good write: `mem[idx] <= wdata`, and `rdata_o` is unchanged.
  - For a good read: `rdata_o <= mem[idx]`.
  - For an error: no array write, and `rdata_o <= 0`.
- **ACK** (one cycle)
  - `ack_o` clears on the next edge.
  - If `req` is low at that edge, go to IDLE; otherwise go to DRAIN.
- **DRAIN**
  - Wait until `req` is low, then go to IDLE.
  - This prevents a level-held request from being serviced twice.
- `rdata_o` and `err_o` hold their values until the next response.
- Reset (async, at any time, including mid-WAIT):
  - `ack_o = 0`, `err_o = 0`, `rdata_o = 0`, state = IDLE, counter = 0.
  - Any pending write is discarded.
  - Array contents are not reset.
- The array is uninitialised after power-up; reads of never-written words return X in simulation.

## Timing
- Request sampled at edge E0 (state IDLE, `req = 1`).
- `ack_o` rises at edge E0+LATENCY and falls at E0+LATENCY+1.
- The array write takes effect at E0+LATENCY. A read issued at or after E0+LATENCY+2 returns the new value.
- Earliest next acceptance:
  - E0+LATENCY+1 if `req` was low at that edge, which means no acceptance then; IDLE is entered at that edge.
  - In practice the earliest new acceptance is E0+LATENCY+2.
  - If `req` is still high at E0+LATENCY+1, the block stays in DRAIN until the first edge sampling `req` low, plus one cycle.
- Throughput is at most one transaction per LATENCY+2 cycles.
- Inputs are sampled only in IDLE (for acceptance) and in ACK/DRAIN (for release). `sel_i` dropping mid-WAIT does not cancel the transaction.

## Test plan
- **Reset values:** assert `rst_i` asynchronously between edges. `ack_o`, `err_o` and `rdata_o` go to 0 immediately, and stay 0 for 5 cycles after release with no request.
- **Write then read, LATENCY=2:**
  - Write `addr=0x10`, `wdata=0xDEADBEEF`, held until ack. `ack_o` is high for exactly 1 cycle at E0+2, with `err_o=0`.
  - Read `0x10` returns `rdata_o=0xDEADBEEF` with ack at E0+2.
- **Errors:**
  - Read `addr=0x13` (misaligned) gives `ack_o=1`, `err_o=1`, `rdata_o=0`.
  - Write `addr=DEPTH*4` gives `err_o=1`; a subsequent read of `0x0` shows that word unchanged.
- **Level hold and DRAIN:**
  - Hold `ren_i=1` for 20 cycles. Exactly one ack pulse is produced.
  - Drop `ren_i` for 1 cycle and raise it again. A second ack follows at LATENCY cycles after re-acceptance.
- **Write priority and select:**
  - `wen_i=ren_i=1`, `addr=0x20`, `wdata=0x1234` performs a write; a readback gives `0x1234`.
  - `wen_i=1` with `sel_i=0` for 10 cycles gives no ack and no array change.
- **Reset mid-WAIT and LATENCY=1:**
  - Assert reset one cycle after accepting a write to `0x40` (previous value `0xA5A5A5A5`). After release, reading `0x40` gives `0xA5A5A5A5`.
  - With LATENCY=1, ack rises at E0+1.
